// File: rtl/priority_shift_reg.sv
// Priority-controlled WIDTH-bit register with a sequenced shift/rotate engine.
// Per-edge priority: clr > pre > load > running shift > start (idle) > hold.
module priority_shift_reg #(
   parameter int unsigned     WIDTH      = 8,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
   parameter int unsigned     CNT_W      = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             pre,
   input  logic             load,
   input  logic [WIDTH-1:0] Din,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] shift_cnt,
   input  logic             ser_in,
   output logic [WIDTH-1:0] Dout,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [1:0] ModeShl  = 2'b00;
   localparam logic [1:0] ModeShr  = 2'b01;
   localparam logic [1:0] ModeRotl = 2'b10;
   localparam logic [1:0] ModeRotr = 2'b11;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ser_q, ser_d;
   logic             done_q, done_d;

   // One-step shift result for the latched mode, computed unconditionally.
   logic [WIDTH-1:0] shifted;
   logic             shifted_out;

   // Datapath for a single shift/rotate step.
   always_comb begin
      shifted     = dout_q;
      shifted_out = 1'b0;
      unique case (mode_q)
         ModeShl: begin
            shifted     = {dout_q[WIDTH-2:0], ser_in};
            shifted_out = dout_q[WIDTH-1];
         end
         ModeShr: begin
            shifted     = {ser_in, dout_q[WIDTH-1:1]};
            shifted_out = dout_q[0];
         end
         ModeRotl: begin
            shifted     = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            shifted_out = dout_q[WIDTH-1];
         end
         ModeRotr: begin
            shifted     = {dout_q[0], dout_q[WIDTH-1:1]};
            shifted_out = dout_q[0];
         end
         default: begin
            shifted     = dout_q;
            shifted_out = 1'b0;
         end
      endcase
   end

   // Next-state logic: priority chain of pre/load/shift/start, clr handled in the register.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      dout_d  = dout_q;
      ser_d   = ser_q;
      done_d  = 1'b0;

      if (pre) begin
         // Preset aborts any running sequence without a done pulse.
         dout_d  = PRESET_VAL;
         state_d = StIdle;
         rem_d   = '0;
      end else if (load) begin
         dout_d  = Din;
         state_d = StIdle;
         rem_d   = '0;
      end else if (state_q == StRun) begin
         dout_d = shifted;
         ser_d  = shifted_out;
         rem_d  = rem_q - CNT_W'(1);
         if (rem_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
      end else if (start) begin
         if (shift_cnt != '0) begin
            state_d = StRun;
            rem_d   = shift_cnt;
            mode_d  = mode;
         end else begin
            // Zero-length sequence completes immediately.
            done_d = 1'b1;
         end
      end
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         rem_q   <= '0;
         mode_q  <= ModeShl;
         dout_q  <= '0;
         ser_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         ser_q   <= ser_d;
         done_q  <= done_d;
      end
   end

   // Outputs are direct register views.
   always_comb begin
      Dout    = dout_q;
      ser_out = ser_q;
      busy    = (state_q == StRun);
      done    = done_q;
   end

endmodule
